logo_scroll_ctrl: RTL and testbench

LOGO_SCROLL_CTRL -- requirements
Module: logo_scroll_ctrl

---
 rtl/logo_scroll_if.sv | 12 +
 rtl/logo_scroll_ctrl.sv | 98 +++++++++
 tb/tb_logo_scroll_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/logo_scroll_if.sv
// Handshake-free signal bundle between the frame driver (vsync/en) and the logo scroll controller.
interface logo_scroll_if;
   logic        en;
   logic        vsync;
   logic [10:0] delt;
   logic        dir;
   logic        moving;
   logic        upd;

   modport master (output en, output vsync, input delt, input dir, input moving, input upd);
   modport slave  (input en, input vsync, output delt, output dir, output moving, output upd);
endinterface

// File: rtl/logo_scroll_ctrl.sv
// Ping-pongs a horizontal logo offset between 0 and MAX_DELT, one STEP per vsync rising edge,
// dwelling PAUSE_FRAMES ticks at each end. Outputs are registered: one cycle from tick to new delt.
module logo_scroll_ctrl #(
   parameter int MAX_DELT     = 200,
   parameter int STEP         = 2,
   parameter int PAUSE_FRAMES = 30
) (
   input logic          clk,
   input logic          rst,
   logo_scroll_if.slave bus
);

   localparam logic [1:0] PAUSE_L = 2'd0;
   localparam logic [1:0] RIGHT   = 2'd1;
   localparam logic [1:0] PAUSE_R = 2'd2;
   localparam logic [1:0] LEFT    = 2'd3;

   localparam logic [11:0] MAX12  = 12'(MAX_DELT);
   localparam logic [11:0] STEP12 = 12'(STEP);
   localparam logic [8:0]  PF9    = 9'(PAUSE_FRAMES);

   logic [1:0]  state_q, state_d;
   logic [10:0] delt_q, delt_d;
   logic [7:0]  pcnt_q, pcnt_d;
   logic        dir_q, dir_d;
   logic        moving_q, moving_d;
   logic        upd_q, upd_d;
   logic        vs_q, vs_d;
   logic        tick;
   logic [11:0] sum;

   always_comb begin
      vs_d    = bus.vsync;
      tick    = bus.vsync & ~vs_q & bus.en;
      state_d = state_q;
      delt_d  = delt_q;
      pcnt_d  = pcnt_q;
      sum     = {1'b0, delt_q} + STEP12;
      if (tick) begin
         case (state_q)
            PAUSE_L, PAUSE_R: begin
               if ({1'b0, pcnt_q} + 9'd1 >= PF9) begin
                  state_d = (state_q == PAUSE_L) ? RIGHT : LEFT;
                  pcnt_d  = '0;
               end else begin
                  pcnt_d = pcnt_q + 8'd1;
               end
            end
            RIGHT: begin
               if (sum >= MAX12) begin
                  delt_d  = MAX12[10:0];
                  state_d = PAUSE_R;
               end else begin
                  delt_d = sum[10:0];
               end
            end
            default: begin
               // compare before subtracting so delt can never wrap below zero
               if ({1'b0, delt_q} <= STEP12) begin
                  delt_d  = '0;
                  state_d = PAUSE_L;
               end else begin
                  delt_d = delt_q - STEP12[10:0];
               end
            end
         endcase
      end
      dir_d    = (state_d == PAUSE_L) || (state_d == RIGHT);
      moving_d = (state_d == RIGHT) || (state_d == LEFT);
      upd_d    = (delt_d != delt_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= PAUSE_L;
         delt_q   <= '0;
         pcnt_q   <= '0;
         dir_q    <= 1'b1;
         moving_q <= 1'b0;
         upd_q    <= 1'b0;
         vs_q     <= 1'b1;
      end else begin
         state_q  <= state_d;
         delt_q   <= delt_d;
         pcnt_q   <= pcnt_d;
         dir_q    <= dir_d;
         moving_q <= moving_d;
         upd_q    <= upd_d;
         vs_q     <= vs_d;
      end
   end

   assign bus.delt   = delt_q;
   assign bus.dir    = dir_q;
   assign bus.moving = moving_q;
   assign bus.upd    = upd_q;

endmodule

// File: tb/tb_logo_scroll_ctrl.sv
// Drives two differently parameterised scroll controllers with shared stimulus and compares them
// against precomputed per-tick offset trajectories.
module tb_logo_scroll_ctrl;

   typedef struct {
      int delt;
      bit dir;
      bit moving;
   } pt_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_chk = 0;
   int   n_bad = 0;

   pt_t tq[$];
   pt_t traj0[$];
   pt_t traj1[$];
   int  idx0 = 0, idx1 = 0;
   bit  prev_vs = 1'b1;
   bit  eu0 = 1'b0, eu1 = 1'b0;
   bit  started = 1'b0;

   logo_scroll_if b0();
   logo_scroll_if b1();

   logo_scroll_ctrl #(.MAX_DELT(10), .STEP(4), .PAUSE_FRAMES(2)) u0 (.clk(clk), .rst(rst), .bus(b0));
   logo_scroll_ctrl #(.MAX_DELT(3),  .STEP(5), .PAUSE_FRAMES(0)) u1 (.clk(clk), .rst(rst), .bus(b1));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Entry k is the visible output after the k-th tick since reset; entry 0 is the reset state.
   task automatic build(input int mx, input int st, input int pf);
      int d;
      int p;
      tq.delete();
      d = 0;
      p = (pf == 0) ? 1 : pf;
      tq.push_back('{0, 1'b1, 1'b0});
      while (tq.size() < 4000) begin
         for (int k = 1; k <= p; k++) tq.push_back('{0, 1'b1, k == p});
         while (d < mx) begin
            d = (d + st >= mx) ? mx : d + st;
            tq.push_back('{d, d != mx, d != mx});
         end
         for (int k = 1; k <= p; k++) tq.push_back('{mx, 1'b0, k == p});
         while (d > 0) begin
            d = (d <= st) ? 0 : d - st;
            tq.push_back('{d, d == 0, d != 0});
         end
      end
   endtask

   task automatic step(input bit r, input bit e, input bit v);
      bit tk;
      @(negedge clk);
      if (started) begin
         chk("u0_delt",   int'(b0.delt),   traj0[idx0].delt);
         chk("u0_dir",    int'(b0.dir),    int'(traj0[idx0].dir));
         chk("u0_moving", int'(b0.moving), int'(traj0[idx0].moving));
         chk("u0_upd",    int'(b0.upd),    int'(eu0));
         chk("u1_delt",   int'(b1.delt),   traj1[idx1].delt);
         chk("u1_dir",    int'(b1.dir),    int'(traj1[idx1].dir));
         chk("u1_moving", int'(b1.moving), int'(traj1[idx1].moving));
         chk("u1_upd",    int'(b1.upd),    int'(eu1));
      end
      rst = r;
      b0.en = e; b0.vsync = v;
      b1.en = e; b1.vsync = v;
      eu0 = 1'b0;
      eu1 = 1'b0;
      if (r) begin
         started = 1'b1;
         idx0 = 0;
         idx1 = 0;
         prev_vs = 1'b1;
      end else begin
         tk = v & ~prev_vs & e;
         prev_vs = v;
         if (tk) begin
            idx0++;
            idx1++;
            eu0 = traj0[idx0].delt != traj0[idx0-1].delt;
            eu1 = traj1[idx1].delt != traj1[idx1-1].delt;
         end
      end
   endtask

   task automatic pulse(input bit e);
      step(1'b0, e, 1'b1);
      step(1'b0, e, 1'b1);
      step(1'b0, e, 1'b0);
      step(1'b0, e, 1'b0);
   endtask

   int s0_exp[12] = '{0, 0, 4, 8, 10, 10, 10, 6, 2, 0, 0, 0};
   int s1_exp[4]  = '{0, 3, 3, 0};

   initial begin
      b0.en = 1'b0; b0.vsync = 1'b0;
      b1.en = 1'b0; b1.vsync = 1'b0;
      build(10, 4, 2);
      traj0 = tq;
      build(3, 5, 0);
      traj1 = tq;

      // vsync already high across reset release must not tick
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 100; i++) step(1'b0, 1'b1, 1'b1);
      chk("hold_u0_delt",   int'(b0.delt),   0);
      chk("hold_u1_moving", int'(b1.moving), 0);
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);

      // twelve frames: full sweep out to 10 and back to 0
      for (int i = 0; i < 12; i++) begin
         pulse(1'b1);
         chk("sweep_u0_delt", int'(b0.delt), s0_exp[i]);
         if (i < 4) chk("short_u1_delt", int'(b1.delt), s1_exp[i]);
         if (i == 0) chk("short_u1_moving", int'(b1.moving), 1);
         if (i == 1) chk("short_u1_dir", int'(b1.dir), 0);
         if (i == 4) chk("fall_u0_dir", int'(b0.dir), 0);
         if (i == 9) chk("rise_u0_dir", int'(b0.dir), 1);
      end

      // disabled frames are dropped, not deferred
      pulse(1'b1);
      chk("right4_delt", int'(b0.delt), 4);
      for (int i = 0; i < 3; i++) begin
         pulse(1'b0);
         chk("en0_delt", int'(b0.delt), 4);
         chk("en0_moving", int'(b0.moving), 1);
      end
      pulse(1'b1);
      chk("after_en_delt", int'(b0.delt), 8);

      // reach LEFT with delt=6, then reset coincident with a tick
      for (int i = 0; i < 4; i++) pulse(1'b1);
      chk("left6_delt", int'(b0.delt), 6);
      chk("left6_dir", int'(b0.dir), 0);
      step(1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b1);
      chk("rst_tick_delt",   int'(b0.delt),   0);
      chk("rst_tick_moving", int'(b0.moving), 0);
      chk("rst_tick_dir",    int'(b0.dir),    1);
      chk("rst_tick_upd",    int'(b0.upd),    0);

      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
      end
      step(1'b0, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
